// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog control stage.
package wdt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WARN = 2'd2,
      ST_BITE = 2'd3
   } wdt_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_TIMEOUT    = 2'd1,
      CAUSE_EARLY_KICK = 2'd2
   } wdt_cause_e;

   // The external counter always restarts from zero.
   localparam int unsigned WDT_CNT_INIT = 0;

endpackage

// File: rtl/wdt_pulse_stretch.sv
// Turns a single-cycle trigger into a level held for RST_PULSE_CYCLES cycles.
// The level starts in the cycle after the trigger. o_last flags the final
// cycle of the pulse so the parent can leave its bite state in step with it.
module wdt_pulse_stretch #(
   parameter int unsigned RST_PULSE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_trigger,
   output logic o_level,
   output logic o_last
);

   localparam int unsigned CW = $clog2(RST_PULSE_CYCLES + 1);

   logic [CW-1:0] r_count;

   // Load the full pulse length on a trigger, then count down to zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (i_trigger) begin
         r_count <= CW'(RST_PULSE_CYCLES);
      end else if (r_count != '0) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_level = (r_count != '0);
   assign o_last  = (r_count == CW'(1));

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog control stage: watches the registered counter value, handles
// software kicks (optionally windowed), raises a sticky warning interrupt and
// issues a stretched reset request when the watchdog bites.
module wdt_ctrl
   import wdt_pkg::*;
#(
   parameter int unsigned CNT_WIDTH        = 32,
   parameter int unsigned RST_PULSE_CYCLES = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_en_i,
   input  logic [CNT_WIDTH-1:0] cfg_timeout_i,
   input  logic [CNT_WIDTH-1:0] cfg_warn_i,
   input  logic                 cfg_win_en_i,
   input  logic [CNT_WIDTH-1:0] cfg_win_i,
   input  logic                 kick_i,
   input  logic                 irq_clr_i,
   input  logic [CNT_WIDTH-1:0] cnt_value_i,
   output logic                 cnt_enable_o,
   output logic                 cnt_clear_o,
   output logic [CNT_WIDTH-1:0] cnt_init_o,
   output logic                 warn_irq_o,
   output logic                 rst_req_o,
   output logic [1:0]           bite_cause_o,
   output logic [1:0]           state_o
);

   wdt_state_e r_state;
   wdt_state_e w_stateNext;
   wdt_cause_e r_cause;
   wdt_cause_e w_causeNext;
   logic       r_warnIrq;

   logic w_timeout;
   logic w_earlyKick;
   logic w_validKick;
   logic w_warnHit;
   logic w_biteTrig;
   logic w_setWarn;
   logic w_cntEnable;
   logic w_cntClear;
   logic w_pulseLevel;
   logic w_pulseLast;

   // Threshold comparisons are unsigned; a window of zero can never reject a kick.
   assign w_timeout   = (cnt_value_i >= cfg_timeout_i);
   assign w_warnHit   = (cnt_value_i >= cfg_warn_i);
   assign w_earlyKick = kick_i && cfg_win_en_i && (cnt_value_i < cfg_win_i);
   assign w_validKick = kick_i && !w_earlyKick;

   // Next-state and counter-control decode; priority inside RUN/WARN is
   // disable, timeout, early kick, valid kick, then warning crossing.
   always_comb begin
      w_stateNext = r_state;
      w_cntEnable = 1'b0;
      w_cntClear  = 1'b0;
      w_biteTrig  = 1'b0;
      w_setWarn   = 1'b0;
      w_causeNext = CAUSE_NONE;
      case (r_state)
         ST_IDLE: begin
            w_cntClear = 1'b1;
            if (cfg_en_i) begin
               w_stateNext = ST_RUN;
            end
         end
         ST_RUN, ST_WARN: begin
            w_cntEnable = 1'b1;
            if (!cfg_en_i) begin
               w_stateNext = ST_IDLE;
            end else if (w_timeout) begin
               w_stateNext = ST_BITE;
               w_biteTrig  = 1'b1;
               w_causeNext = CAUSE_TIMEOUT;
            end else if (w_earlyKick) begin
               w_stateNext = ST_BITE;
               w_biteTrig  = 1'b1;
               w_causeNext = CAUSE_EARLY_KICK;
            end else if (w_validKick) begin
               w_cntClear  = 1'b1;
               w_stateNext = ST_RUN;
            end else if ((r_state == ST_RUN) && w_warnHit) begin
               w_stateNext = ST_WARN;
               w_setWarn   = 1'b1;
            end
         end
         ST_BITE: begin
            w_cntClear = 1'b1;
            if (w_pulseLast) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Sticky warning interrupt; a new warning wins over a simultaneous clear.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_warnIrq <= 1'b0;
      end else if (w_setWarn) begin
         r_warnIrq <= 1'b1;
      end else if (irq_clr_i) begin
         r_warnIrq <= 1'b0;
      end
   end

   // Bite cause is captured on every bite and otherwise held until reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cause <= CAUSE_NONE;
      end else if (w_biteTrig) begin
         r_cause <= w_causeNext;
      end
   end

   wdt_pulse_stretch #(
      .RST_PULSE_CYCLES(RST_PULSE_CYCLES)
   ) u_pulse (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_trigger(w_biteTrig),
      .o_level  (w_pulseLevel),
      .o_last   (w_pulseLast)
   );

   assign cnt_enable_o = w_cntEnable;
   assign cnt_clear_o  = w_cntClear;
   assign cnt_init_o   = CNT_WIDTH'(WDT_CNT_INIT);
   assign warn_irq_o   = r_warnIrq;
   assign rst_req_o    = w_pulseLevel;
   assign bite_cause_o = r_cause;
   assign state_o      = r_state;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Testbench for wdt_ctrl: a bench-side counter closes the loop, a behavioural
// model is compared every cycle, and directed scenarios pin literal values.
module tb_wdt_ctrl;

   localparam int PULSE = 16;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_WARN = 2;
   localparam int M_BITE = 3;

   logic        clk = 1'b0;
   logic        rstN;
   logic        cfgEn;
   logic [31:0] cfgTimeout;
   logic [31:0] cfgWarn;
   logic        cfgWinEn;
   logic [31:0] cfgWin;
   logic        kick;
   logic        irqClr;
   logic [31:0] cntValue = 32'd0;
   logic        cntEnable;
   logic        cntClear;
   logic [31:0] cntInit;
   logic        warnIrq;
   logic        rstReq;
   logic [1:0]  biteCause;
   logic [1:0]  stateO;

   int total = 0;
   int bad   = 0;

   int mState    = M_IDLE;
   int mBiteLeft = 0;
   int mCause    = 0;
   bit mWarn     = 1'b0;
   bit modelValid = 1'b0;

   wdt_ctrl #(
      .CNT_WIDTH(32),
      .RST_PULSE_CYCLES(PULSE)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .cfg_en_i     (cfgEn),
      .cfg_timeout_i(cfgTimeout),
      .cfg_warn_i   (cfgWarn),
      .cfg_win_en_i (cfgWinEn),
      .cfg_win_i    (cfgWin),
      .kick_i       (kick),
      .irq_clr_i    (irqClr),
      .cnt_value_i  (cntValue),
      .cnt_enable_o (cntEnable),
      .cnt_clear_o  (cntClear),
      .cnt_init_o   (cntInit),
      .warn_irq_o   (warnIrq),
      .rst_req_o    (rstReq),
      .bite_cause_o (biteCause),
      .state_o      (stateO)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Sibling counter: clear reloads zero, enable increments, value lags a cycle.
   always @(posedge clk) begin
      if (cntClear === 1'b1) begin
         cntValue <= 32'd0;
      end else if (cntEnable === 1'b1) begin
         cntValue <= cntValue + 32'd1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Watchdog behaviour described as rules: what happens this cycle given the
   // current phase, the counter value and the software inputs.
   always @(posedge clk) begin : modelStep
      int  ns;
      int  nl;
      int  nc;
      bit  setW;
      bit  tHit;
      bit  early;
      if (!rstN) begin
         mState     <= M_IDLE;
         mBiteLeft  <= 0;
         mCause     <= 0;
         mWarn      <= 1'b0;
         modelValid <= 1'b1;
      end else begin
         ns    = mState;
         nl    = mBiteLeft;
         nc    = mCause;
         setW  = 1'b0;
         tHit  = (cntValue >= cfgTimeout);
         early = kick && cfgWinEn && (cntValue < cfgWin);
         if (mState == M_BITE) begin
            nl = mBiteLeft - 1;
            if (nl == 0) ns = M_IDLE;
         end else if (mState == M_IDLE) begin
            if (cfgEn) ns = M_RUN;
         end else if (!cfgEn) begin
            ns = M_IDLE;
         end else if (tHit || early) begin
            ns = M_BITE;
            nl = PULSE;
            nc = tHit ? 1 : 2;
         end else if (kick) begin
            ns = M_RUN;
         end else if (mState == M_RUN && cntValue >= cfgWarn) begin
            ns   = M_WARN;
            setW = 1'b1;
         end
         mState    <= ns;
         mBiteLeft <= nl;
         mCause    <= nc;
         mWarn     <= setW ? 1'b1 : (irqClr ? 1'b0 : mWarn);
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin : compareStep
      bit active;
      bit expClear;
      #2;
      if (modelValid) begin
         active   = (mState == M_RUN) || (mState == M_WARN);
         expClear = (mState == M_IDLE) || (mState == M_BITE) ||
                    (active && cfgEn && !(cntValue >= cfgTimeout) &&
                     !(cfgWinEn && cntValue < cfgWin) && kick);
         checkOutput("cyc_state", {30'd0, stateO}, mState);
         checkOutput("cyc_rst_req", {31'd0, rstReq}, (mState == M_BITE) ? 1 : 0);
         checkOutput("cyc_warn_irq", {31'd0, warnIrq}, {31'd0, mWarn});
         checkOutput("cyc_cause", {30'd0, biteCause}, mCause);
         checkOutput("cyc_cnt_clear", {31'd0, cntClear}, {31'd0, expClear});
         checkOutput("cyc_cnt_enable", {31'd0, cntEnable}, {31'd0, active});
         checkOutput("cyc_cnt_init", cntInit, 32'd0);
      end
   end

   // One-cycle strobe on kick and/or irq clear, ending at the next negedge.
   task automatic applyStimulus(input logic kickVal, input logic clrVal);
      kick   = kickVal;
      irqClr = clrVal;
      @(negedge clk);
      kick   = 1'b0;
      irqClr = 1'b0;
   endtask

   task automatic waitCnt(input logic [31:0] target, input int budget);
      int n = 0;
      @(negedge clk);
      while (cntValue !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (cntValue !== target) begin
         checkOutput("wait_cnt_timeout", cntValue, target);
      end
   endtask

   task automatic waitState(input logic [1:0] target, input int budget);
      int n = 0;
      @(negedge clk);
      while (stateO !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (stateO !== target) begin
         checkOutput("wait_state_timeout", {30'd0, stateO}, {30'd0, target});
      end
   endtask

   initial begin : stimulus
      int pulses;
      rstN = 1'b0; cfgEn = 1'b0; cfgTimeout = 32'd100; cfgWarn = 32'd80;
      cfgWinEn = 1'b0; cfgWin = 32'd0; kick = 1'b0; irqClr = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_state", {30'd0, stateO}, 0);
      checkOutput("reset_clear", {31'd0, cntClear}, 1);
      checkOutput("reset_enable", {31'd0, cntEnable}, 0);
      checkOutput("reset_rst_req", {31'd0, rstReq}, 0);
      checkOutput("reset_cause", {30'd0, biteCause}, 0);
      checkOutput("reset_warn", {31'd0, warnIrq}, 0);
      rstN  = 1'b1;
      cfgEn = 1'b1;

      // Free-running to warn and timeout.
      waitCnt(32'd80, 200);
      checkOutput("s1_pre_warn", {31'd0, warnIrq}, 0);
      @(negedge clk);
      checkOutput("s1_warn_set", {31'd0, warnIrq}, 1);
      checkOutput("s1_warn_state", {30'd0, stateO}, 2);
      waitCnt(32'd100, 200);
      @(negedge clk);
      checkOutput("s1_bite_state", {30'd0, stateO}, 3);
      checkOutput("s1_cause", {30'd0, biteCause}, 1);
      pulses = 0;
      while (rstReq === 1'b1 && pulses < 40) begin
         pulses++;
         @(negedge clk);
      end
      checkOutput("s1_pulse_len", pulses, 16);
      checkOutput("s1_idle_after", {30'd0, stateO}, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("s1_rerun", {30'd0, stateO}, 1);
      checkOutput("s1_warn_cleared", {31'd0, warnIrq}, 0);

      // Kicks keep the watchdog alive; a kick beats the warn crossing.
      waitCnt(32'd50, 200);
      applyStimulus(1'b1, 1'b0);
      checkOutput("s2_cnt_cleared", cntValue, 0);
      checkOutput("s2_no_warn", {31'd0, warnIrq}, 0);
      for (int i = 0; i < 4; i++) begin
         repeat (59) @(negedge clk);
         applyStimulus(1'b1, 1'b0);
         checkOutput("s2_periodic_run", {30'd0, stateO}, 1);
      end
      waitCnt(32'd80, 200);
      applyStimulus(1'b1, 1'b0);
      checkOutput("s2_kick_at_warn_state", {30'd0, stateO}, 1);
      checkOutput("s2_kick_at_warn_irq", {31'd0, warnIrq}, 0);
      checkOutput("s2_kick_at_warn_cnt", cntValue, 0);

      // Window mode: early kick bites, kick at the window edge is accepted.
      cfgWinEn = 1'b1;
      cfgWin   = 32'd40;
      waitCnt(32'd20, 200);
      applyStimulus(1'b1, 1'b0);
      checkOutput("s3_early_state", {30'd0, stateO}, 3);
      checkOutput("s3_early_cause", {30'd0, biteCause}, 2);
      waitState(2'd1, 40);
      waitCnt(32'd40, 200);
      applyStimulus(1'b1, 1'b0);
      checkOutput("s3_ok_state", {30'd0, stateO}, 1);
      checkOutput("s3_ok_cnt", cntValue, 0);

      // Timeout beats a simultaneous kick; warn set beats a simultaneous clear.
      cfgWinEn = 1'b0;
      waitCnt(32'd100, 200);
      applyStimulus(1'b1, 1'b0);
      checkOutput("s4_tmo_state", {30'd0, stateO}, 3);
      checkOutput("s4_tmo_cause", {30'd0, biteCause}, 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("s4_warn_clr", {31'd0, warnIrq}, 0);
      waitState(2'd1, 40);
      waitCnt(32'd80, 200);
      applyStimulus(1'b0, 1'b1);
      checkOutput("s4_set_wins", {31'd0, warnIrq}, 1);
      checkOutput("s4_warn_state", {30'd0, stateO}, 2);

      // Disable while in WARN.
      cfgEn = 1'b0;
      @(negedge clk);
      checkOutput("s5_idle", {30'd0, stateO}, 0);
      checkOutput("s5_clear", {31'd0, cntClear}, 1);
      checkOutput("s5_warn_kept", {31'd0, warnIrq}, 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("s5_warn_clr", {31'd0, warnIrq}, 0);

      // Warn above timeout never fires; reset mid-pulse aborts the bite.
      cfgTimeout = 32'd10;
      cfgWarn    = 32'd200;
      cfgEn      = 1'b1;
      waitState(2'd3, 40);
      checkOutput("s6_no_warn", {31'd0, warnIrq}, 0);
      checkOutput("s6_cause", {30'd0, biteCause}, 1);
      repeat (4) @(negedge clk);
      checkOutput("s6_pulse5", {31'd0, rstReq}, 1);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("s6_abort_req", {31'd0, rstReq}, 0);
      checkOutput("s6_abort_state", {30'd0, stateO}, 0);
      checkOutput("s6_abort_cause", {30'd0, biteCause}, 0);
      rstN = 1'b1;

      // Zero timeout bites on the first RUN cycle.
      cfgTimeout = 32'd0;
      @(negedge clk);
      checkOutput("s7_run", {30'd0, stateO}, 1);
      @(negedge clk);
      checkOutput("s7_bite", {30'd0, stateO}, 3);
      checkOutput("s7_cause", {30'd0, biteCause}, 1);
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
